// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the byte-wide instruction memory
// and the control unit: memory read port plus the instruction
// valid/ready handshake. The fetch unit is the master side.
interface instr_fetch_unit_if;
  logic [7:0] mem_addr;
  logic       mem_rw;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;

  modport master (
    output mem_addr,
    output mem_rw,
    input  mem_data,
    output instr_valid,
    input  instr_ready,
    output instr_opcode,
    output instr_operand,
    output instr_pc
  );

  modport slave (
    input  mem_addr,
    input  mem_rw,
    output mem_data,
    input  instr_valid,
    output instr_ready,
    input  instr_opcode,
    input  instr_operand,
    input  instr_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads one byte per
// cycle from the instruction memory, assembles 1- or 2-byte instructions
// (opcode[7] selects the length) and hands them to the control unit over
// valid/ready. Supports single-cycle branch redirects and stops after
// delivering HALT_OPCODE.
//
// Optional feature: define IFETCH_STALL_CNT_EN to add a 16-bit saturating
// stall_cnt output counting cycles with instr_valid=1 and instr_ready=0.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               branch_en,
  input  logic [7:0]         branch_addr,
  output logic               halted,
`ifdef IFETCH_STALL_CNT_EN
  output logic [15:0]        stall_cnt,
`endif
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_OP  = 3'd1,
    S_FETCH_ARG = 3'd2,
    S_DELIVER   = 3'd3,
    S_HALTED    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] operand_q, operand_d;
  logic [7:0] instr_pc_q, instr_pc_d;

  logic       handshake;
  logic       branch_take;

  // Decode handshake and whether a redirect applies in the current state
  always_comb begin
    handshake   = (state_q == S_DELIVER) && bus.instr_ready;
    branch_take = branch_en && (state_q != S_IDLE);
  end

  // Next-state, PC and instruction-register computation
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;

    if (branch_take) begin
      // A redirect discards any partial fetch and beats run, halt and
      // a same-cycle handshake (the delivered instruction still counts
      // as consumed because valid drops next cycle).
      pc_d    = branch_addr;
      state_d = S_FETCH_OP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            pc_d    = RESET_PC;
            state_d = S_FETCH_OP;
          end
        end

        S_FETCH_OP: begin
          opcode_d   = bus.mem_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 8'd1;
          if (bus.mem_data[7]) begin
            state_d = S_FETCH_ARG;
          end else begin
            operand_d = 8'h00;
            state_d   = S_DELIVER;
          end
        end

        S_FETCH_ARG: begin
          operand_d = bus.mem_data;
          pc_d      = pc_q + 8'd1;
          state_d   = S_DELIVER;
        end

        S_DELIVER: begin
          if (handshake) begin
            state_d = (opcode_q == HALT_OPCODE) ? S_HALTED : S_FETCH_OP;
          end
        end

        S_HALTED: begin
          if (run) begin
            pc_d    = RESET_PC;
            state_d = S_FETCH_OP;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      instr_pc_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Outputs are decoded from registered state so they drop at reset
  always_comb begin
    bus.mem_addr      = pc_q;
    bus.mem_rw        = (state_q == S_FETCH_OP) || (state_q == S_FETCH_ARG);
    bus.instr_valid   = (state_q == S_DELIVER);
    bus.instr_opcode  = opcode_q;
    bus.instr_operand = operand_q;
    bus.instr_pc      = instr_pc_q;
    halted            = (state_q == S_HALTED);
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of backpressure cycles; only reset clears it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.instr_valid && !bus.instr_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drive the stall count port
  always_comb begin
    stall_cnt = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: byte-wide memory model read on
// negedge, linear stimulus sequence, immediate-assertion checks.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       run;
  logic       branch_en;
  logic [7:0] branch_addr;
  logic       halted;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] mem [256];

  int total;
  int passed;

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .halted      (halted),
`ifdef IFETCH_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered address, data updated on negedge
  always @(negedge clk) begin
    if (bus.mem_rw) bus.mem_data <= mem[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ins();
    return {8'h00, bus.instr_pc, bus.instr_opcode, bus.instr_operand};
  endfunction

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'hFF;
    mem[8'h02] = 8'h00;

    rst             = 1'b1;
    run             = 1'b0;
    branch_en       = 1'b0;
    branch_addr     = 8'h00;
    bus.instr_ready = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_addr",   {24'd0, bus.mem_addr}, 32'h00);
    chk("rst_instr",  ins(), 32'h000000);
    rst = 1'b0;

    // Branch in IDLE is ignored
    branch_en   = 1'b1;
    branch_addr = 8'h50;
    tick();
    branch_en = 1'b0;
    chk("idle_br_rw",   {31'd0, bus.mem_rw}, 32'd0);
    chk("idle_br_addr", {24'd0, bus.mem_addr}, 32'h00);

    // Test 1: 1-byte instruction then HALT (HALT is 2-byte, operand mem[2])
    run             = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    run = 1'b0;
    chk("t1_fop_rw",   {31'd0, bus.mem_rw}, 32'd1);
    chk("t1_fop_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("t1_i0_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t1_i0",       ins(), 32'h001200);
    tick();
    chk("t1_hs_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("t1_hs_addr",  {24'd0, bus.mem_addr}, 32'h01);
    tick();
    chk("t1_arg_addr", {24'd0, bus.mem_addr}, 32'h02);
    tick();
    chk("t1_i1_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t1_i1",       ins(), 32'h01FF00);
    tick();
    chk("t1_halted",   {31'd0, halted}, 32'd1);
    chk("t1_halt_rw",  {31'd0, bus.mem_rw}, 32'd0);
    chk("t1_halt_vld", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("t1_halted2",  {31'd0, halted}, 32'd1);

    // Test 2: 2-byte instruction with 5 cycles of backpressure
    mem[8'h00]      = 8'h85;
    mem[8'h01]      = 8'h3C;
    bus.instr_ready = 1'b0;
    run             = 1'b1;
    tick();
    run = 1'b0;
    chk("t2_unhalt",   {31'd0, halted}, 32'd0);
    chk("t2_fop_addr", {24'd0, bus.mem_addr}, 32'h00);
    tick();
    chk("t2_farg_vld", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_vld", {31'd0, bus.instr_valid}, 32'd1);
      chk("t2_hold",     ins(), 32'h00853C);
      tick();
    end
    chk("t2_after_vld", {31'd0, bus.instr_valid}, 32'd1);
    chk("t2_after",     ins(), 32'h00853C);
`ifdef IFETCH_STALL_CNT_EN
    chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_hs_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("t2_hs_addr",  {24'd0, bus.mem_addr}, 32'h02);

    // Test 3: wrap-around, 2-byte instruction at 8'hFF
    mem[8'hFF]  = 8'h90;
    mem[8'h00]  = 8'h7A;
    branch_en   = 1'b1;
    branch_addr = 8'hFF;
    tick();
    branch_en = 1'b0;
    chk("t3_br_addr",  {24'd0, bus.mem_addr}, 32'hFF);
    chk("t3_br_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("t3_wrap_addr", {24'd0, bus.mem_addr}, 32'h00);
    tick();
    chk("t3_valid",    {31'd0, bus.instr_valid}, 32'd1);
    chk("t3_instr",    ins(), 32'hFF907A);
    tick();
    chk("t3_next_addr", {24'd0, bus.mem_addr}, 32'h01);
    chk("t3_next_rw",   {31'd0, bus.mem_rw}, 32'd1);

    // Test 4: branch during FETCH_ARG of a 2-byte instruction at 8'h10
    mem[8'h10]  = 8'hA5;
    mem[8'h11]  = 8'h11;
    mem[8'h40]  = 8'h05;
    branch_en   = 1'b1;
    branch_addr = 8'h10;
    tick();
    branch_en = 1'b0;
    chk("t4_fop_addr", {24'd0, bus.mem_addr}, 32'h10);
    tick();
    chk("t4_farg_addr", {24'd0, bus.mem_addr}, 32'h11);
    chk("t4_farg_vld",  {31'd0, bus.instr_valid}, 32'd0);
    branch_en   = 1'b1;
    branch_addr = 8'h40;
    tick();
    branch_en = 1'b0;
    chk("t4_abort_vld",  {31'd0, bus.instr_valid}, 32'd0);
    chk("t4_abort_addr", {24'd0, bus.mem_addr}, 32'h40);
    tick();
    chk("t4_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t4_instr", ins(), 32'h400500);
    tick();

    // Test 5: HALT handshake together with a branch to 8'h20
    mem[8'h30]      = 8'hFF;
    mem[8'h31]      = 8'h00;
    mem[8'h20]      = 8'h07;
    bus.instr_ready = 1'b0;
    branch_en       = 1'b1;
    branch_addr     = 8'h30;
    tick();
    branch_en = 1'b0;
    tick();
    tick();
    chk("t5_halt_vld", {31'd0, bus.instr_valid}, 32'd1);
    chk("t5_halt_ins", ins(), 32'h30FF00);
`ifdef IFETCH_STALL_CNT_EN
    chk("t5_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif
    bus.instr_ready = 1'b1;
    branch_en       = 1'b1;
    branch_addr     = 8'h20;
    tick();
    branch_en       = 1'b0;
    bus.instr_ready = 1'b0;
    chk("t5_not_halted", {31'd0, halted}, 32'd0);
    chk("t5_br_addr",    {24'd0, bus.mem_addr}, 32'h20);
    chk("t5_br_rw",      {31'd0, bus.mem_rw}, 32'd1);
    chk("t5_br_vld",     {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("t5_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("t5_instr", ins(), 32'h200700);

    // Test 6: asynchronous reset while instr_valid=1
    rst = 1'b1;
    #1;
    chk("t6_valid",  {31'd0, bus.instr_valid}, 32'd0);
    chk("t6_rw",     {31'd0, bus.mem_rw}, 32'd0);
    chk("t6_halted", {31'd0, halted}, 32'd0);
    chk("t6_addr",   {24'd0, bus.mem_addr}, 32'h00);
    chk("t6_instr",  ins(), 32'h000000);
`ifdef IFETCH_STALL_CNT_EN
    chk("t6_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_rw", {31'd0, bus.mem_rw}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage between the 256×8 instruction memory and the control unit. Holds the program counter, drives the memory read address and read enable, and assembles one- or two-byte instructions from the byte-wide memory output. Presents each instruction to the control unit over a valid/ready handshake. Also handles branch redirects and the HALT opcode.

## Interface
- RESET_PC, 8'h00, PC value after reset and the start address for a `run` pulse
- HALT_OPCODE, 8'hFF, opcode that stops fetching after it is delivered
- clk  input  1  system clock; memory reads on negedge, this block acts on posedge
- rst  input  1  asynchronous, active-high reset
- run  input  1  start fetching from RESET_PC; sampled only in IDLE or HALTED
- mem_addr  output  8  read address to instruction memory; always equals PC
- mem_rw  output  1  1 = memory read enable; high only in FETCH_OP and FETCH_ARG
- mem_data  input  8  byte from instruction memory, updated on negedge clk
- instr_valid  output  1  instruction outputs are valid
- instr_ready  input  1  control unit accepts the instruction
- instr_opcode  output  8  first byte of the instruction
- instr_operand  output  8  second byte if opcode[7]=1, else 8'h00
- instr_pc  output  8  address of the opcode byte
- branch_en  input  1  single-cycle redirect request
- branch_addr  input  8  redirect target
- halted  output  1  HALT has been delivered and fetching has stopped

## Operation
- Instruction format:
  - opcode[7]=0 means a 1-byte instruction.
  - opcode[7]=1 means a 2-byte instruction; the operand is at PC+1.
- Reset values (asynchronous): state IDLE, PC=RESET_PC, mem_rw=0, instr_valid=0, instr_opcode=instr_operand=instr_pc=8'h00, halted=0.
- States and transitions:
  - IDLE: when `run`=1, load PC=RESET_PC and go to FETCH_OP.
  - FETCH_OP: mem_rw=1. On posedge, capture mem_data into opcode, set instr_pc=PC, PC=PC+1. If opcode[7]=1 go to FETCH_ARG; otherwise set operand=0 and go to DELIVER.
  - FETCH_ARG: mem_rw=1. On posedge, capture operand, PC=PC+1, go to DELIVER.
  - DELIVER: instr_valid=1. Outputs stay stable until instr_valid && instr_ready. On handshake: if opcode==HALT_OPCODE go to HALTED, else go to FETCH_OP.
  - HALTED: halted=1, mem_rw=0. `run` restarts from RESET_PC and clears halted.
- PC arithmetic is 8-bit modulo; 8'hFF+1 wraps to 8'h00. A 2-byte instruction at 8'hFF takes its operand from 8'h00.
- Branch handling:
  - branch_en in FETCH_OP, FETCH_ARG, DELIVER or HALTED: PC=branch_addr, instr_valid=0 and halted=0 next cycle, next state FETCH_OP. Any partially fetched instruction is discarded.
  - branch_en together with a handshake in the same cycle: the instruction counts as consumed, the branch still wins, and HALT is not entered.
  - branch_en in IDLE is ignored.
- If `run` and branch_en are both active in HALTED, branch_en has priority.
- Reset asserted mid-fetch or mid-handshake returns all outputs to their reset values immediately.

## Timing
- Memory access: mem_addr is registered. The memory updates mem_data on the following negedge. This block samples it on the next posedge, so each byte costs one cycle.
- run sampled at posedge k:
  - FETCH_OP during cycle k+1.
  - 1-byte instruction: instr_valid high from k+2.
  - 2-byte instruction: instr_valid high from k+3.
- Handshake at cycle j: instr_valid is low in cycle j+1 (FETCH_OP). Steady-state throughput is one 1-byte instruction per 2 cycles, or one 2-byte instruction per 3 cycles, when instr_ready is held high.
- Branch at cycle b: FETCH_OP at branch_addr in cycle b+1. The first valid instruction appears no earlier than b+2.
- instr_* outputs must not change while instr_valid=1 and instr_ready=0.

## Configuration
- IFETCH_STALL_CNT_EN: when defined, adds output port stall_cnt (16 bits).
  - Counts cycles with instr_valid=1 && instr_ready=0.
  - Saturates at 16'hFFFF, cleared by rst, unaffected by branch and run.
- When not defined, the port and counter are absent and all other behaviour is identical.

## Test plan
- Single-byte program: mem[0]=8'h12, mem[1]=8'hFF, instr_ready=1, `run` pulse.
  - Expect {pc 00, op 12, arg 00}, then {pc 01, op FF}.
  - Expect halted=1 and mem_rw=0 after the second handshake.
- Two-byte instruction with backpressure: mem[0]=8'h85, mem[1]=8'h3C, instr_ready low for 5 cycles.
  - Outputs hold {00, 85, 3C} for all 5 cycles.
  - With the macro defined, stall_cnt=5.
- Wrap-around: branch to 8'hFF with mem[FF]=8'h90, mem[00]=8'h7A.
  - Expect {pc FF, op 90, arg 7A}.
  - Next opcode fetched from 8'h01.
- Branch abort: assert branch_en (addr 8'h40) during FETCH_ARG of a 2-byte instruction at 8'h10.
  - No valid for 8'h10.
  - Next delivered instruction has pc 40.
- Simultaneous events: handshake of HALT_OPCODE with branch_en=1 to 8'h20.
  - halted stays 0 and fetch resumes at 8'h20.
  - Separately, assert rst while instr_valid=1: all outputs return to reset values immediately.
